// File: rtl/ace_desc_retire_if.sv
// Completion handshake between the slave datapath and the descriptor retire block.
interface ace_desc_retire_if #(
  parameter int unsigned MAX_DESC   = 8,
  parameter int unsigned RESP_WIDTH = 2
);
  localparam int unsigned DESC_IDX_WIDTH = (MAX_DESC > 1) ? $clog2(MAX_DESC) : 1;

  logic                      txn_cmpl_valid;
  logic                      txn_cmpl_ready;
  logic [DESC_IDX_WIDTH-1:0] txn_cmpl_idx;
  logic [RESP_WIDTH-1:0]     txn_cmpl_resp;

  modport master (
    output txn_cmpl_valid,
    output txn_cmpl_idx,
    output txn_cmpl_resp,
    input  txn_cmpl_ready
  );

  modport slave (
    input  txn_cmpl_valid,
    input  txn_cmpl_idx,
    input  txn_cmpl_resp,
    output txn_cmpl_ready
  );
endinterface

// File: rtl/ace_desc_retire.sv
// Descriptor retire path: tracks busy per descriptor, queues datapath completions and
// retires them (response write, ownership-clear pulse, busy clear, sticky completion status).
module ace_desc_retire #(
  parameter  int unsigned MAX_DESC       = 8,
  parameter  int unsigned RESP_WIDTH     = 2,
  localparam int unsigned DESC_IDX_WIDTH = (MAX_DESC > 1) ? $clog2(MAX_DESC) : 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      desc_alc_valid,
  input  logic [DESC_IDX_WIDTH-1:0] desc_alc_idx,
  ace_desc_retire_if.slave          cmpl,
  output logic [MAX_DESC-1:0]       int_status_busy_busy,
  output logic [MAX_DESC-1:0]       own_clr,
  output logic                      resp_wr_en,
  output logic [DESC_IDX_WIDTH-1:0] resp_wr_idx,
  output logic [RESP_WIDTH-1:0]     resp_wr_data,
  input  logic [MAX_DESC-1:0]       intr_comp_clear,
  input  logic [MAX_DESC-1:0]       intr_comp_enable,
  output logic [MAX_DESC-1:0]       intr_comp_status,
  output logic                      irq_out,
  output logic                      err_unexp_cmpl
);

  localparam int unsigned ENTRY_W   = DESC_IDX_WIDTH + RESP_WIDTH;
  localparam int unsigned CNT_W     = $clog2(MAX_DESC + 1);
  localparam int unsigned DESC_SPAN = 1 << DESC_IDX_WIDTH;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LATCH  = 3'd2,
    RESP   = 3'd3,
    RETIRE = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [ENTRY_W-1:0]        fifo_mem [MAX_DESC];
  logic [DESC_IDX_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [ENTRY_W-1:0]        fifo_dout_q;
  logic                      ready_q;
  logic                      push, pop;

  logic [DESC_IDX_WIDTH-1:0] dout_idx;
  logic [RESP_WIDTH-1:0]     dout_resp;
  logic [DESC_SPAN-1:0]      busy_span;
  logic                      err_set, cur_load;
  logic [MAX_DESC-1:0]       retire_mask, alloc_mask;

  function automatic logic [MAX_DESC-1:0] onehot(input logic [DESC_IDX_WIDTH-1:0] i);
    return MAX_DESC'(1) << i;
  endfunction

  function automatic logic [DESC_IDX_WIDTH-1:0] ptr_inc(input logic [DESC_IDX_WIDTH-1:0] p);
    return (p == DESC_IDX_WIDTH'(MAX_DESC - 1)) ? '0 : p + DESC_IDX_WIDTH'(1);
  endfunction

  assign push                = cmpl.txn_cmpl_valid & ready_q;
  assign pop                 = (state_q == POP);
  assign cmpl.txn_cmpl_ready = ready_q;
  assign dout_idx            = fifo_dout_q[ENTRY_W-1:RESP_WIDTH];
  assign dout_resp           = fifo_dout_q[RESP_WIDTH-1:0];
  // Out-of-range indices land in the zero padding and read as not busy.
  assign busy_span           = DESC_SPAN'(int_status_busy_busy);
  assign retire_mask         = (state_q == RETIRE) ? onehot(resp_wr_idx) : '0;
  assign alloc_mask          = desc_alc_valid ? onehot(desc_alc_idx) : '0;
  assign irq_out             = |(intr_comp_status & intr_comp_enable);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Completion FIFO storage; contents need no reset, occupancy does.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {cmpl.txn_cmpl_idx, cmpl.txn_cmpl_resp};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_dout_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d != CNT_W'(MAX_DESC));
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop) begin
        rd_ptr_q    <= ptr_inc(rd_ptr_q);
        fifo_dout_q <= fifo_mem[rd_ptr_q];
      end
    end
  end

  // Retire sequencer next-state.
  always_comb begin
    state_d  = state_q;
    err_set  = 1'b0;
    cur_load = 1'b0;
    case (state_q)
      IDLE:   if (count_q != '0) state_d = POP;
      POP:    state_d = LATCH;
      LATCH: begin
        if (busy_span[dout_idx]) begin
          state_d  = RESP;
          cur_load = 1'b1;
        end else begin
          state_d = IDLE;
          err_set = 1'b1;
        end
      end
      RESP:   state_d = RETIRE;
      RETIRE: state_d = (count_q != '0) ? POP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // resp_wr_idx doubles as the current descriptor until the next retirement loads it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q              <= IDLE;
      resp_wr_en           <= 1'b0;
      resp_wr_idx          <= '0;
      resp_wr_data         <= '0;
      own_clr              <= '0;
      int_status_busy_busy <= '0;
      intr_comp_status     <= '0;
      err_unexp_cmpl       <= 1'b0;
    end else begin
      state_q    <= state_d;
      resp_wr_en <= (state_d == RESP);
      own_clr    <= (state_d == RETIRE) ? onehot(resp_wr_idx) : '0;
      if (cur_load) begin
        resp_wr_idx  <= dout_idx;
        resp_wr_data <= dout_resp;
      end
      // Set beats clear on the same index in the same cycle.
      int_status_busy_busy <= (int_status_busy_busy & ~retire_mask) | alloc_mask;
      intr_comp_status     <= (intr_comp_status & ~intr_comp_clear) | retire_mask;
      err_unexp_cmpl       <= err_unexp_cmpl | err_set;
    end
  end

endmodule
